// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared state encoding and frame-size helpers for conv_layer_scheduler
package conv_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int calc_nin(input int width, input int height);
    return width * height;
  endfunction

  function automatic int calc_nout(input int width, input int height, input int filter);
    return (width - filter + 1) * (height - filter + 1);
  endfunction

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_sched_counter.sv
// rtl/conv_sched_counter.sv - clear/enable counter over 0..MAX_COUNT-1 with terminal flag
module conv_sched_counter
  import conv_sched_pkg::*;
#(
  parameter int MAX_COUNT = 16,
  parameter int WIDTH     = cnt_width(MAX_COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  assign terminal = (count == WIDTH'(MAX_COUNT - 1));

  // Wrapping at the terminal value leaves the counter ready for the next frame.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - frame scheduler feeding a streaming conv layer; optional CONV_SCHED_PERF_EN cycle counter
module conv_layer_scheduler
  import conv_sched_pkg::*;
#(
  parameter int I_WIDTH       = 8,
  parameter int O_WIDTH       = 16,
  parameter int CHANNELS_IN   = 3,
  parameter int CHANNELS_OUT  = 5,
  parameter int FILTER_SIZE   = 5,
  parameter int IMAGE_WIDTH   = 64,
  parameter int IMAGE_HEIGHT  = 32,
  parameter int DRAIN_TIMEOUT = 1024,
  localparam int NIN    = calc_nin(IMAGE_WIDTH, IMAGE_HEIGHT),
  localparam int NOUT   = calc_nout(IMAGE_WIDTH, IMAGE_HEIGHT, FILTER_SIZE),
  localparam int IA_W   = cnt_width(NIN),
  localparam int OA_W   = cnt_width(NOUT),
  localparam int IDLE_W = cnt_width(DRAIN_TIMEOUT)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [IA_W-1:0]                 in_addr,
  input  logic [CHANNELS_IN*I_WIDTH-1:0]  in_data,
  output logic                            conv_clk_en,
  output logic [CHANNELS_IN*I_WIDTH-1:0]  conv_input_data,
  input  logic [CHANNELS_OUT*O_WIDTH-1:0] conv_output_data,
  input  logic                            conv_valid,
  output logic [CHANNELS_OUT*O_WIDTH-1:0] out_data,
  output logic [OA_W-1:0]                 out_addr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            error,
  output logic [31:0]                     perf_cycles
);

  state_t state, state_next;

  logic active, frame_start, xfer;
  logic in_en, in_term, out_term;
  logic idle_en, idle_clr, idle_term, timeout;
  logic [IDLE_W-1:0] idle_count_unused;

  assign active      = (state == S_FEED) || (state == S_DRAIN);
  assign frame_start = (state == S_IDLE) && start;

  // out_ready low freezes the layer together with every counter.
  assign conv_clk_en     = active && out_ready;
  assign conv_input_data = (state == S_FEED) ? in_data : '0;

  assign out_valid = conv_valid && active;
  assign out_data  = conv_output_data;
  assign xfer      = out_valid && out_ready;

  assign in_en    = (state == S_FEED) && out_ready;
  assign idle_en  = (state == S_DRAIN) && out_ready && !xfer;
  assign idle_clr = frame_start || xfer || (state != S_DRAIN);
  assign timeout  = idle_en && idle_term;

  conv_sched_counter #(.MAX_COUNT(NIN), .WIDTH(IA_W)) u_in_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (frame_start),
    .enable   (in_en),
    .count    (in_addr),
    .terminal (in_term)
  );

  conv_sched_counter #(.MAX_COUNT(NOUT), .WIDTH(OA_W)) u_out_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (frame_start),
    .enable   (xfer),
    .count    (out_addr),
    .terminal (out_term)
  );

  conv_sched_counter #(.MAX_COUNT(DRAIN_TIMEOUT), .WIDTH(IDLE_W)) u_idle_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (idle_clr),
    .enable   (idle_en),
    .count    (idle_count_unused),
    .terminal (idle_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The final transfer wins over the last-pixel handoff so a frame can finish from FEED.
  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_FEED;
      end
      S_FEED: begin
        if (xfer && out_term)       state_next = S_DONE;
        else if (in_en && in_term)  state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if ((xfer && out_term) || timeout) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      error <= 1'b0;
    end else if (timeout) begin
      error <= 1'b1;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_count;

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      perf_count <= '0;
    end else if (state != S_IDLE) begin
      perf_count <= perf_count + 32'd1;
    end
  end

  assign perf_cycles = perf_count;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb/tb_conv_layer_scheduler.sv - randomized self-checking bench with a window-sum layer model
module tb_conv_layer_scheduler;

  localparam int IW = 8, OW = 16, CI = 3, CO = 5;
  localparam int F = 3, W = 8, H = 6, TO = 16, L = 3;
  localparam int NIN = W * H;
  localparam int OWID = W - F + 1;
  localparam int NOUT = OWID * (H - F + 1);
  localparam int IDW = CI * IW;
`ifdef CONV_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, out_ready;
  logic busy, done, conv_clk_en, conv_valid, out_valid, error;
  logic [5:0] in_addr;
  logic [4:0] out_addr;
  logic [IDW-1:0] in_data, conv_input_data;
  logic [CO*OW-1:0] conv_output_data, out_data;
  logic [31:0] perf_cycles;

  int tests = 0;
  int fails = 0;

  logic [IDW-1:0] mem [64];

  always #5 clk = ~clk;

  assign in_data = mem[in_addr];

  conv_layer_scheduler #(
    .I_WIDTH(IW), .O_WIDTH(OW), .CHANNELS_IN(CI), .CHANNELS_OUT(CO),
    .FILTER_SIZE(F), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data), .conv_clk_en(conv_clk_en),
    .conv_input_data(conv_input_data), .conv_output_data(conv_output_data),
    .conv_valid(conv_valid), .out_data(out_data), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready), .error(error),
    .perf_cycles(perf_cycles)
  );

  // Layer model: window sum of channel 0 over FxF, emitted L enabled cycles after its last pixel.
  logic pv [L];
  logic [CO*OW-1:0] pd [L];
  logic [IW-1:0] cap [NIN];
  int feed_k, produced, out_limit;

  assign conv_valid = pv[L-1];
  assign conv_output_data = pd[L-1];

  function automatic bit window_done(input int k);
    return (k < NIN) && (k / W >= F - 1) && (k % W >= F - 1);
  endfunction

  function automatic logic [CO*OW-1:0] pack_sum(input int s);
    logic [CO*OW-1:0] r;
    for (int j = 0; j < CO; j++) r[j*OW +: OW] = OW'(s + j);
    return r;
  endfunction

  function automatic logic [CO*OW-1:0] layer_out(input int k, input logic [IW-1:0] cur);
    int s = 0;
    if (!window_done(k)) return '0;
    for (int dr = 0; dr < F; dr++)
      for (int dc = 0; dc < F; dc++) begin
        int idx = k - dr * W - dc;
        s += (idx == k) ? int'(cur) : int'(cap[idx]);
      end
    return pack_sum(s);
  endfunction

  always @(posedge clk) begin
    if (reset || (start && !busy)) begin
      for (int i = 0; i < L; i++) pv[i] <= 1'b0;
      feed_k <= 0;
      produced <= 0;
    end else if (conv_clk_en) begin
      pv[0] <= window_done(feed_k) && (produced < out_limit);
      pd[0] <= layer_out(feed_k, conv_input_data[IW-1:0]);
      if (window_done(feed_k) && (produced < out_limit)) produced <= produced + 1;
      if (feed_k < NIN) cap[feed_k] <= conv_input_data[IW-1:0];
      feed_k <= feed_k + 1;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  // Reference: output n is the window whose top-left pixel is (n / OWID, n % OWID).
  function automatic logic [CO*OW-1:0] exp_out(input int n);
    int orow = n / OWID;
    int ocol = n % OWID;
    int s = 0;
    for (int dr = 0; dr < F; dr++)
      for (int dc = 0; dc < F; dc++)
        s += int'(mem[(orow + dr) * W + ocol + dc][IW-1:0]);
    return pack_sum(s);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 64; i++) mem[i] = (i < NIN) ? IDW'($urandom) : '0;
  endtask

  int r_fed, r_xfers, r_addr_errs, r_data_errs, r_drain_errs;
  int r_dones, r_done_cyc, r_stall_low, r_stall_errs;

  // Runs one frame from a negedge; cycle 0 carries the start pulse.
  task automatic run_frame(input int stall_at, input int stall_len, input int restart_at,
                           input int max_cycles);
    int held_in = 0;
    int held_out = 0;
    r_fed = 0; r_xfers = 0; r_addr_errs = 0; r_data_errs = 0; r_drain_errs = 0;
    r_dones = 0; r_done_cyc = -1; r_stall_low = 0; r_stall_errs = 0;
    for (int c = 0; c < max_cycles; c++) begin
      start = (c == 0) || (c == restart_at);
      out_ready = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
      #1;
      if (conv_clk_en) begin
        if (r_fed < NIN) begin
          if (int'(in_addr) != r_fed) r_addr_errs++;
          r_fed++;
        end else if (conv_input_data !== '0) begin
          r_drain_errs++;
        end
      end
      if (!out_ready) begin
        if (c == stall_at) begin
          held_in = int'(in_addr);
          held_out = int'(out_addr);
        end
        if (!conv_clk_en) r_stall_low++;
      end
      if (stall_len > 0 && c > stall_at && c <= stall_at + stall_len &&
          (int'(in_addr) != held_in || int'(out_addr) != held_out)) r_stall_errs++;
      if (out_valid && out_ready) begin
        if (int'(out_addr) != r_xfers) r_addr_errs++;
        if (r_xfers >= NOUT || out_data !== exp_out(r_xfers)) r_data_errs++;
        r_xfers++;
      end
      if (done) begin
        r_dones++;
        if (r_done_cyc < 0) r_done_cyc = c;
      end
      @(negedge clk);
      if (r_done_cyc >= 0 && c >= r_done_cyc + 2) break;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; out_limit = 1000;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (conv_clk_en !== 1'b0) begin fails++; $display("FAIL reset_clk_en got %b want 0", conv_clk_en); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got %b want 0", error); end
    tests++; if (perf_cycles !== 32'd0) begin fails++; $display("FAIL reset_perf got %0d want 0", perf_cycles); end
    tests++; if (in_addr !== 6'd0 || out_addr !== 5'd0) begin fails++; $display("FAIL reset_addr got %0d/%0d want 0/0", in_addr, out_addr); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill_mem(); out_limit = 1000;
    run_frame(-1, 0, -1, 150);
    tests++; if (r_fed != NIN) begin fails++; $display("FAIL basic_fed got %0d want %0d", r_fed, NIN); end
    tests++; if (r_xfers != NOUT) begin fails++; $display("FAIL basic_xfers got %0d want %0d", r_xfers, NOUT); end
    tests++; if (r_addr_errs != 0) begin fails++; $display("FAIL basic_addr errors got %0d want 0", r_addr_errs); end
    tests++; if (r_data_errs != 0) begin fails++; $display("FAIL basic_data errors got %0d want 0", r_data_errs); end
    tests++; if (r_drain_errs != 0) begin fails++; $display("FAIL basic_drain_zero errors got %0d want 0", r_drain_errs); end
    tests++; if (r_dones != 1) begin fails++; $display("FAIL basic_done_count got %0d want 1", r_dones); end
    tests++; if (r_done_cyc != NIN + L + 1) begin fails++; $display("FAIL basic_done_cycle got %0d want %0d", r_done_cyc, NIN + L + 1); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL basic_error got %b want 0", error); end
    tests++; if (perf_cycles !== (PERF ? 32'd52 : 32'd0)) begin fails++; $display("FAIL basic_perf got %0d want %0d", perf_cycles, PERF ? 52 : 0); end
  endtask

  task automatic test_stall();
    int at = int'($urandom_range(10, 40));
    fill_mem(); out_limit = 1000;
    run_frame(at, 5, -1, 150);
    tests++; if (r_stall_low != 5) begin fails++; $display("FAIL stall_clk_en_low got %0d want 5", r_stall_low); end
    tests++; if (r_stall_errs != 0) begin fails++; $display("FAIL stall_addr_frozen errors got %0d want 0", r_stall_errs); end
    tests++; if (r_fed != NIN || r_xfers != NOUT) begin fails++; $display("FAIL stall_counts got %0d/%0d want %0d/%0d", r_fed, r_xfers, NIN, NOUT); end
    tests++; if (r_addr_errs != 0 || r_data_errs != 0) begin fails++; $display("FAIL stall_stream errors got %0d/%0d want 0/0", r_addr_errs, r_data_errs); end
    tests++; if (r_done_cyc != NIN + L + 1 + 5) begin fails++; $display("FAIL stall_done_cycle got %0d want %0d", r_done_cyc, NIN + L + 6); end
    tests++; if (perf_cycles !== (PERF ? 32'd57 : 32'd0)) begin fails++; $display("FAIL stall_perf got %0d want %0d", perf_cycles, PERF ? 57 : 0); end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    int dones = 0;
    fill_mem(); out_limit = 1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (busy && in_addr == 6'd20) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    tests++; if (seen != 1) begin fails++; $display("FAIL midreset_reach_20 got %0d want 1", seen); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midreset_idle busy/done got %b/%b want 0/0", busy, done); end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (done) dones++;
    end
    tests++; if (dones != 0) begin fails++; $display("FAIL midreset_no_done got %0d want 0", dones); end
    @(negedge clk);
    fill_mem();
    run_frame(-1, 0, -1, 150);
    tests++; if (r_fed != NIN || r_xfers != NOUT || r_dones != 1) begin fails++; $display("FAIL midreset_next_frame got %0d/%0d/%0d want %0d/%0d/1", r_fed, r_xfers, r_dones, NIN, NOUT); end
    tests++; if (r_data_errs != 0 || r_addr_errs != 0) begin fails++; $display("FAIL midreset_next_stream errors got %0d/%0d want 0/0", r_data_errs, r_addr_errs); end
  endtask

  task automatic test_timeout();
    fill_mem(); out_limit = 10;
    run_frame(-1, 0, -1, 150);
    tests++; if (r_xfers != 10) begin fails++; $display("FAIL timeout_xfers got %0d want 10", r_xfers); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL timeout_error got %b want 1", error); end
    tests++; if (r_done_cyc != NIN + 1 + TO) begin fails++; $display("FAIL timeout_done_cycle got %0d want %0d", r_done_cyc, NIN + 1 + TO); end
    tests++; if (r_dones != 1) begin fails++; $display("FAIL timeout_done_count got %0d want 1", r_dones); end
    out_limit = 1000;
  endtask

  task automatic test_restart();
    fill_mem(); out_limit = 1000;
    run_frame(-1, 0, int'($urandom_range(5, 40)), 150);
    tests++; if (r_dones != 1) begin fails++; $display("FAIL restart_done_count got %0d want 1", r_dones); end
    tests++; if (r_fed != NIN || r_xfers != NOUT || r_addr_errs != 0) begin fails++; $display("FAIL restart_counts got %0d/%0d addr errors %0d want %0d/%0d/0", r_fed, r_xfers, r_addr_errs, NIN, NOUT); end
    tests++; if (r_done_cyc != NIN + L + 1) begin fails++; $display("FAIL restart_done_cycle got %0d want %0d", r_done_cyc, NIN + L + 1); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL restart_error_cleared got %b want 0", error); end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      fill_mem(); out_limit = 1000;
      run_frame(-1, 0, -1, 150);
      tests++; if (r_xfers != NOUT || r_data_errs != 0) begin fails++; $display("FAIL b2b_frame%0d xfers %0d data errors %0d want %0d/0", f, r_xfers, r_data_errs, NOUT); end
      tests++; if (r_done_cyc != NIN + L + 1) begin fails++; $display("FAIL b2b_frame%0d done_cycle got %0d want %0d", f, r_done_cyc, NIN + L + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_mid_reset();
    test_timeout();
    test_restart();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
